lc3_mem_responder: RTL
======================

Name: lc3_mem_responder

Overview:
Synthesizable memory-side responder for the LC3 core's instruction and data memory interfaces. It is the other end of the pc/instrmem_rd/Instr_dout/complete_instr and Data_addr/Data_rd/Data_din/Data_dout/complete_data protocol. It holds a word-addressed memory, answers fetches and loads/stores with programmable wait states, and offers a backdoor load port so the bench can preload programs. It replaces the behavioural memory model in top-level simulation and gives stall-controllable timing for core verification.

Parameters:
ADDR_W, 16, memory address width; depth = 2**ADDR_W words of 16 bits.
LAT_W, 4, width of the per-request wait-state inputs.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-low reset.
pc  in  16  fetch address; low ADDR_W bits are used.
instrmem_rd  in  1  fetch request; held high until complete_instr.
Instr_dout  out  16  fetched instruction; valid while complete_instr=1.
complete_instr  out  1  fetch done strobe.
data_en  in  1  data request valid.
Data_addr  in  16  data address.
Data_rd  in  1  1 = load, 0 = store.
Data_din  in  16  store data from core.
Data_dout  out  16  load data to core; valid while complete_data=1.
complete_data  out  1  data done strobe.
fetch_wait  in  LAT_W  wait states for the next accepted fetch.
data_wait  in  LAT_W  wait states for the next accepted data access.
load_en  in  1  backdoor write enable.
load_addr  in  16  backdoor address.
load_data  in  16  backdoor data.
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0 at an edge): both port FSMs go to IDLE; counters are 0; proto_err=0; complete_* are 0 and *_dout are 0 during and after reset until a completion. Memory contents are not cleared. Reset mid-wait aborts the access; a pending store is not committed.
- Each port has an independent 2-state FSM: IDLE, WAIT.
- IDLE with a request (instrmem_rd=1, or data_en=1 for the data port):
  - If the sampled wait value w = 0: complete is asserted combinationally in the same cycle. dout = mem[addr], read combinationally. The FSM stays in IDLE.
  - If w > 0: capture addr (plus Data_rd and Data_din for the data port), load cnt = w-1, go to WAIT.
- WAIT:
  - If the request drops: go to IDLE with no completion, and no store is committed.
  - Else if cnt = 0: assert complete for one cycle with dout = mem[captured addr], then go to IDLE.
  - Else: decrement cnt.
- Latency: completion occurs exactly w cycles after the accepting cycle. A request still held after completion is a new request, accepted on the next cycle. A continuously held request with w=0 therefore completes every cycle.
- Stores commit mem[addr] <= Data_din at the clock edge ending the completion cycle. Data_dout stays 0 for stores.
- Read-during-write to the same address, including a fetch against a store: the reader sees the old value; the new value is visible from the next cycle.
- The backdoor write commits at the edge whenever load_en=1. It has priority over a same-cycle, same-address store, and that store is dropped.
- proto_err is set and held until reset when, in WAIT:
  - pc differs from the captured fetch address, or
  - Data_addr or Data_rd differs from the captured data values.
- Address bits above ADDR_W are ignored, so the address wraps modulo depth.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - port_state_e (IDLE, WAIT);
  - the word width constant (16);
  - the default LAT_W.
- Sub-module lc3_mem_port holds the FSM, wait counter, address capture and proto check. It is instantiated twice: fetch with write disabled, and data.
- The memory array and the write arbitration live in the top block.

Test Plan:
- Backdoor-load mem[0x3000]=0x1261, fetch pc=0x3000 with fetch_wait=0 -> complete_instr=1 and Instr_dout=0x1261 in the same cycle.
- fetch_wait=3 at pc=0x3001 holding mem 0x5020 -> complete_instr low for 3 cycles, high on cycle 3 with 0x5020 for exactly one cycle.
- Store Data_addr=0x4000, Data_din=0xBEEF, data_wait=2, then load 0x4000 with data_wait=0 -> the load returns 0xBEEF; a fetch of 0x4000 in the store's completion cycle returns the old value.
- Drop instrmem_rd during WAIT (fetch_wait=5, drop at cycle 2) -> no complete_instr. Also change pc during WAIT -> proto_err=1, held until reset.
- Store to 0x4010 alongside load_en to 0x4010 with 0x1111 -> mem[0x4010]=0x1111.
- Assert reset=0 mid-WAIT of a store -> complete_*=0, the store is not committed, and mem is otherwise unchanged.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and widths for the LC3 memory responder
`timescale 1ns/1ps
package lc3_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } port_state_e;

    localparam int WORD_W        = 16;
    localparam int DEFAULT_LAT_W = 4;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - core-facing fetch/data/backdoor bundle for the LC3 memory responder
`timescale 1ns/1ps
interface lc3_mem_responder_if
    import lc3_mem_pkg::*;
#(
    parameter int LAT_W = DEFAULT_LAT_W
);
    logic [WORD_W-1:0] pc;
    logic              instrmem_rd;
    logic [WORD_W-1:0] Instr_dout;
    logic              complete_instr;

    logic              data_en;
    logic [WORD_W-1:0] Data_addr;
    logic              Data_rd;
    logic [WORD_W-1:0] Data_din;
    logic [WORD_W-1:0] Data_dout;
    logic              complete_data;

    logic [LAT_W-1:0]  fetch_wait;
    logic [LAT_W-1:0]  data_wait;

    logic              load_en;
    logic [WORD_W-1:0] load_addr;
    logic [WORD_W-1:0] load_data;

    logic              proto_err;

    modport master (
        output pc, instrmem_rd, data_en, Data_addr, Data_rd, Data_din,
               fetch_wait, data_wait, load_en, load_addr, load_data,
        input  Instr_dout, complete_instr, Data_dout, complete_data, proto_err
    );

    modport slave (
        input  pc, instrmem_rd, data_en, Data_addr, Data_rd, Data_din,
               fetch_wait, data_wait, load_en, load_addr, load_data,
        output Instr_dout, complete_instr, Data_dout, complete_data, proto_err
    );

endinterface

// File: rtl/lc3_mem_port.sv
// rtl/lc3_mem_port.sv - one request port: wait-state FSM, request capture and protocol check
`timescale 1ns/1ps
module lc3_mem_port
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int LAT_W    = DEFAULT_LAT_W,
    parameter bit WRITE_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic [WORD_W-1:0] din,
    input  logic [LAT_W-1:0]  wait_val,
    output logic              complete,
    output logic              is_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              store_en,
    output logic [WORD_W-1:0] store_data,
    output logic              err
);

    port_state_e       state;
    port_state_e       state_next;
    logic [LAT_W-1:0]  cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_rd;
    logic [WORD_W-1:0] cap_din;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: zero-wait requests never leave IDLE; a dropped request abandons the access
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req && (wait_val != '0)) state_next = WAIT;
            WAIT: if (!req || (cnt == '0))     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: IDLE serves the live request, WAIT serves the captured one
    always_comb begin
        complete   = 1'b0;
        mem_addr   = addr;
        is_load    = rd;
        store_data = din;
        case (state)
            IDLE: complete = req && (wait_val == '0);
            WAIT: begin
                mem_addr   = cap_addr;
                is_load    = cap_rd;
                store_data = cap_din;
                complete   = req && (cnt == '0);
            end
            default: complete = 1'b0;
        endcase
        complete = complete && reset;
        store_en = WRITE_EN && complete && !is_load;
    end

    // Capture the request on acceptance and count down the remaining wait states
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            cap_addr <= '0;
            cap_rd   <= 1'b0;
            cap_din  <= '0;
        end else if (state == IDLE) begin
            if (req && (wait_val != '0)) begin
                cnt      <= wait_val - LAT_W'(1);
                cap_addr <= addr;
                cap_rd   <= rd;
                cap_din  <= din;
            end
        end else if (req && (cnt != '0)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    // Sticky flag: the requester must hold address and direction steady while waiting
    always_ff @(posedge clock) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((state == WAIT) && ((addr != cap_addr) || (rd != cap_rd))) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - word memory answering LC3 fetch and data requests with wait states
`timescale 1ns/1ps
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT_W  = DEFAULT_LAT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_mem_responder_if.slave   bus
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    logic              f_complete;
    logic              f_is_load;
    logic [ADDR_W-1:0] f_addr;
    logic              f_store_en;
    logic [WORD_W-1:0] f_store_data;
    logic              f_err;

    logic              d_complete;
    logic              d_is_load;
    logic [ADDR_W-1:0] d_addr;
    logic              d_store_en;
    logic [WORD_W-1:0] d_store_data;
    logic              d_err;

    lc3_mem_port #(
        .ADDR_W   (ADDR_W),
        .LAT_W    (LAT_W),
        .WRITE_EN (1'b0)
    ) u_fetch (
        .clock      (clock),
        .reset      (reset),
        .req        (bus.instrmem_rd),
        .addr       (bus.pc[ADDR_W-1:0]),
        .rd         (1'b1),
        .din        ('0),
        .wait_val   (bus.fetch_wait),
        .complete   (f_complete),
        .is_load    (f_is_load),
        .mem_addr   (f_addr),
        .store_en   (f_store_en),
        .store_data (f_store_data),
        .err        (f_err)
    );

    lc3_mem_port #(
        .ADDR_W   (ADDR_W),
        .LAT_W    (LAT_W),
        .WRITE_EN (1'b1)
    ) u_data (
        .clock      (clock),
        .reset      (reset),
        .req        (bus.data_en),
        .addr       (bus.Data_addr[ADDR_W-1:0]),
        .rd         (bus.Data_rd),
        .din        (bus.Data_din),
        .wait_val   (bus.data_wait),
        .complete   (d_complete),
        .is_load    (d_is_load),
        .mem_addr   (d_addr),
        .store_en   (d_store_en),
        .store_data (d_store_data),
        .err        (d_err)
    );

    // Memory writes: port stores first, backdoor last so it wins a same-address collision
    always_ff @(posedge clock) begin
        if (f_store_en) begin
            mem[f_addr] <= f_store_data;
        end
        if (d_store_en) begin
            mem[d_addr] <= d_store_data;
        end
        if (bus.load_en) begin
            mem[bus.load_addr[ADDR_W-1:0]] <= bus.load_data;
        end
    end

    // Reads are combinational, so a same-cycle writer is seen only from the next cycle
    assign bus.Instr_dout     = (f_complete && f_is_load) ? mem[f_addr] : '0;
    assign bus.complete_instr = f_complete;
    assign bus.Data_dout      = (d_complete && d_is_load) ? mem[d_addr] : '0;
    assign bus.complete_data  = d_complete;
    assign bus.proto_err      = f_err | d_err;

endmodule
